// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch stage: widths, HALT opcode field
// location and queue depth.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 10;
  localparam int FETCH_DATA_W  = 19;
  localparam int OPCODE_MSB    = 18;
  localparam int OPCODE_LSB    = 14;
  localparam int FETCH_Q_DEPTH = 2;

  localparam logic [4:0] HALT_OPCODE = 5'b11111;

  function automatic logic is_halt_word(input logic [FETCH_DATA_W-1:0] w);
    return w[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order FIFO of {pc, instr} between fetch and decode. Entry 0 is
// the registered head; push and pop may coincide at any occupancy.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = FETCH_ADDR_W,
  parameter int DATA_WIDTH = FETCH_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_instr,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [1:0]            o_count
);

  logic [ADDR_WIDTH-1:0] r_pc    [FETCH_Q_DEPTH];
  logic [DATA_WIDTH-1:0] r_instr [FETCH_Q_DEPTH];
  logic [1:0]            r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 2'd0;
      for (int i = 0; i < FETCH_Q_DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          r_pc[r_count[0]]    <= i_pc;
          r_instr[r_count[0]] <= i_instr;
          r_count             <= r_count + 2'd1;
        end
        2'b01: begin
          r_pc[0]    <= r_pc[1];
          r_instr[0] <= r_instr[1];
          r_count    <= r_count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the new word lands behind whatever survives the pop.
          if (r_count == 2'd2) begin
            r_pc[0]    <= r_pc[1];
            r_instr[0] <= r_instr[1];
            r_pc[1]    <= i_pc;
            r_instr[1] <= i_instr;
          end else begin
            r_pc[0]    <= i_pc;
            r_instr[0] <= i_instr;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_pc    = r_pc[0];
  assign o_instr = r_instr[0];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one-deep ROM read tracking, credit-based issue and the
// decode queue. Optional HALT detection is enabled by defining FETCH_HALT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = FETCH_ADDR_W,
  parameter int                    DATA_WIDTH = FETCH_DATA_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  output logic                  halted
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_inflight_pc;
  logic                  r_inflight;

  logic [1:0] w_count;
  logic [2:0] w_need;
  logic       w_pop;
  logic       w_push;
  logic       w_credit;
  logic       w_block;
  logic       w_issue;

  assign w_pop  = instr_valid & instr_ready;
  assign w_push = r_inflight & ~redirect_valid;

  // Queue slots already promised (held + in flight) must leave room after this cycle's pop.
  assign w_need   = {1'b0, w_count} + {2'b00, r_inflight};
  assign w_credit = w_need < (3'd2 + {2'b00, w_pop});
  assign w_issue  = ~redirect_valid & ~w_block & w_credit;

`ifdef FETCH_HALT_EN
  logic r_halt_seen;
  logic w_halt_push;

  assign w_halt_push = w_push & is_halt_word(rom_dout);
  // Blocking the issue that coincides with the HALT push keeps anything behind it out.
  assign w_block     = r_halt_seen | w_halt_push;
  assign halted      = r_halt_seen & (w_count == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_halt_seen <= 1'b0;
    else if (redirect_valid) r_halt_seen <= 1'b0;
    else if (w_halt_push)    r_halt_seen <= 1'b1;
  end
`else
  assign w_block = 1'b0;
  assign halted  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + 1'b1;
      end
    end
  end

  assign rom_addr = r_pc;

  fetch_queue #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_queue (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_flush(redirect_valid),
    .i_pc   (r_inflight_pc),
    .i_instr(rom_dout),
    .o_valid(instr_valid),
    .o_pc   (instr_pc),
    .o_instr(instr),
    .o_count(w_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected {pc, instr}, a
// negedge monitor checks every accepted instruction in order.
module tb_fetch_unit;

  localparam int AW = 10;
  localparam int DW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout = '0;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;
  logic          halted;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC('0)) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_addr      (rom_addr),
    .rom_dout      (rom_dout),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .halted        (halted)
  );

  logic [DW-1:0] mem [1024];
  always @(posedge clk) rom_dout <= mem[rom_addr];

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_extra = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && instr_valid && instr_ready) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("deliver_pc", 32'(instr_pc), 32'(e.pc));
        check("deliver_instr", 32'(instr), 32'(e.ins));
      end else if (chk_extra) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_delivery: got pc 0x%0h, expected no delivery", instr_pc);
      end
    end
  end

  task automatic push_seq(input logic [AW-1:0] start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc  = start + AW'(i);
      e.ins = mem[e.pc];
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int maxc);
    int k = 0;
    while (exp_q.size() > 0 && k < maxc) begin
      tick();
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic redirect_to(input logic [AW-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    tick();
    tick();
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // Cold start, then a stall in cycles 5..9
    push_seq(10'h000, 20);
    instr_ready = 1'b1;
    rst = 1'b0;
    tick();
    check("cold_c1_valid", 32'(instr_valid), 32'd0);
    tick();
    check("cold_c2_valid", 32'(instr_valid), 32'd1);
    check("cold_c2_pc", 32'(instr_pc), 32'd0);
    tick();
    tick();
    tick();
    instr_ready = 1'b0;
    for (int c = 6; c <= 9; c++) begin
      tick();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_pc", 32'(instr_pc), 32'd3);
      check("stall_instr", 32'(instr), 32'd3);
      check("stall_rom_addr", 32'(rom_addr), 32'd5);
    end
    tick();
    instr_ready = 1'b1;
    drain("drain_stream", 40);

    // Redirect with a full queue
    instr_ready = 1'b0;
    tick();
    tick();
    tick();
    exp_q.delete();
    push_seq(10'h200, 6);
    redirect_to(10'h200);
    instr_ready = 1'b1;
    check("redir_r1_valid", 32'(instr_valid), 32'd0);
    check("redir_r1_rom_addr", 32'(rom_addr), 32'h200);
    tick();
    check("redir_r2_valid", 32'(instr_valid), 32'd0);
    tick();
    check("redir_r3_valid", 32'(instr_valid), 32'd1);
    check("redir_r3_pc", 32'(instr_pc), 32'h200);
    drain("drain_redirect", 30);

    // PC wrap
    instr_ready = 1'b0;
    tick();
    exp_q.delete();
    push_seq(10'h3FE, 4);
    redirect_to(10'h3FE);
    instr_ready = 1'b1;
    drain("drain_wrap", 30);

    // Back-to-back redirects: last one wins
    instr_ready = 1'b0;
    tick();
    exp_q.delete();
    push_seq(10'h150, 3);
    redirect_valid = 1'b1;
    redirect_pc    = 10'h100;
    tick();
    redirect_pc    = 10'h150;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    check("dbl_redir_rom_addr", 32'(rom_addr), 32'h150);
    drain("drain_dbl_redirect", 30);

    // Asynchronous reset mid-stream with a full queue
    instr_ready = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(instr_valid), 32'd0);
    check("async_rst_instr", 32'(instr), 32'd0);
    check("async_rst_instr_pc", 32'(instr_pc), 32'd0);
    check("async_rst_rom_addr", 32'(rom_addr), 32'd0);
    check("async_rst_halted", 32'(halted), 32'd0);
    exp_q.delete();
    tick();
    tick();
    push_seq(10'h000, 4);
    instr_ready = 1'b1;
    rst = 1'b0;
    tick();
    check("restart_c1_valid", 32'(instr_valid), 32'd0);
    tick();
    check("restart_c2_valid", 32'(instr_valid), 32'd1);
    check("restart_c2_pc", 32'(instr_pc), 32'd0);
    drain("drain_restart", 30);

    // HALT word at address 4
    instr_ready = 1'b0;
    mem[4] = {5'b11111, 14'h0004};
    rst = 1'b1;
    tick();
    exp_q.delete();
    rst = 1'b0;
    instr_ready = 1'b1;
`ifdef FETCH_HALT_EN
    push_seq(10'h000, 5);
    chk_extra = 1'b1;
    drain("drain_to_halt", 30);
    check("halted_after_pop", 32'(halted), 32'd1);
    check("halt_rom_addr", 32'(rom_addr), 32'd5);
    for (int c = 0; c < 6; c++) tick();
    check("halted_hold", 32'(halted), 32'd1);
    check("halt_no_valid", 32'(instr_valid), 32'd0);
    push_seq(10'h000, 5);
    redirect_to(10'h000);
    check("halt_cleared", 32'(halted), 32'd0);
    drain("drain_after_halt", 30);
    chk_extra = 1'b0;
`else
    push_seq(10'h000, 8);
    drain("drain_past_halt_word", 30);
    check("never_halted", 32'(halted), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
